// File: rtl/fn_pkg.sv
// ============================================================================
// Module   : fn_pkg
// Purpose  : Shared definitions for the iterative branch comparator:
//            funct3 comparison codes, FSM state encoding and result helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fn_pkg;

    // RISC-V branch funct3 codes
    localparam logic [2:0] FN_EQ  = 3'b000;
    localparam logic [2:0] FN_NE  = 3'b001;
    localparam logic [2:0] FN_LT  = 3'b100;
    localparam logic [2:0] FN_GE  = 3'b101;
    localparam logic [2:0] FN_LTU = 3'b110;
    localparam logic [2:0] FN_GEU = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        COMPARAR = 2'd1,
        FIN      = 2'd2
    } estado_t;

    // Signed modes get their sign bits inverted so the chunk walk stays unsigned
    function automatic logic fn_es_signo(input logic [2:0] m);
        return (m == FN_LT) || (m == FN_GE);
    endfunction

    // Final branch outcome from equality/less-than flags; illegal codes yield 0
    function automatic logic fn_resultado(input logic [2:0] m,
                                          input logic      ig,
                                          input logic      me);
        logic r;
        case (m)
            FN_EQ:         r = ig;
            FN_NE:         r = !ig;
            FN_LT, FN_LTU: r = me;
            FN_GE, FN_GEU: r = !me;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fn_comparar_paso.sv
// ============================================================================
// Module   : fn_comparar_paso
// Purpose  : Combinational PASO-bit unsigned chunk comparator.
//            dif   = chunks differ
//            menor = chunk a is below chunk b (unsigned)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fn_comparar_paso #(
    parameter int PASO = 8
) (
    input  logic [PASO-1:0] a,
    input  logic [PASO-1:0] b,
    output logic            dif,
    output logic            menor
);

    assign dif   = (a != b);
    assign menor = (a < b);

endmodule

`default_nettype wire

// File: rtl/fn_comparar_iter.sv
// ============================================================================
// Module   : fn_comparar_iter
// Purpose  : Iterative RISC-V branch comparator (EQ/NE/LT/GE/LTU/GEU).
//            Walks the operands PASO bits per clock from MSB to LSB with a
//            start/done handshake (inicio / listo). All outputs registered.
// Config   : FN_COMPARAR_SALIDA_ANTICIPADA_EN - when defined, the walk stops
//            on the first differing chunk instead of always taking N steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fn_comparar_iter
    import fn_pkg::*;
#(
    parameter int ANCHO = 32,
    parameter int PASO  = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             inicio,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic [2:0]       modo,
    output logic             ocupado,
    output logic             listo,
    output logic             Y,
    output logic             igual,
    output logic             menor
);

    localparam int N     = ANCHO / PASO;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ANCHO-1:0] SIGNO   = {1'b1, {(ANCHO-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    estado_t          estado_q;
    logic [ANCHO-1:0] a_q;
    logic [ANCHO-1:0] b_q;
    logic [2:0]       modo_q;
    logic [IDX_W-1:0] idx_q;
    logic             dif_q;
    logic             menor_int_q;
    logic             ocupado_q;
    logic             listo_q;
    logic             y_q;
    logic             igual_q;
    logic             menor_q;

    logic [PASO-1:0]  chunk_a;
    logic [PASO-1:0]  chunk_b;
    logic             chunk_dif;
    logic             chunk_menor;
    logic             dif_d;
    logic             menor_int_d;
    logic             termina;

    // Single comparator, fed with the chunk currently selected by idx
    assign chunk_a = a_q[idx_q*PASO +: PASO];
    assign chunk_b = b_q[idx_q*PASO +: PASO];

    fn_comparar_paso #(
        .PASO (PASO)
    ) u_paso (
        .a     (chunk_a),
        .b     (chunk_b),
        .dif   (chunk_dif),
        .menor (chunk_menor)
    );

    // Only the most significant differing chunk decides the ordering
    always_comb begin
        dif_d       = dif_q | chunk_dif;
        menor_int_d = menor_int_q;
        if (!dif_q && chunk_dif) begin
            menor_int_d = chunk_menor;
        end
    end

`ifdef FN_COMPARAR_SALIDA_ANTICIPADA_EN
    // Stop at the first difference; equal operands still walk every chunk
    assign termina = (idx_q == '0) || (!dif_q && chunk_dif);
`else
    // Fixed latency: always walk all N chunks
    assign termina = (idx_q == '0);
`endif

    // Controller with registered handshake and result outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            estado_q    <= ESPERA;
            a_q         <= '0;
            b_q         <= '0;
            modo_q      <= '0;
            idx_q       <= '0;
            dif_q       <= 1'b0;
            menor_int_q <= 1'b0;
            ocupado_q   <= 1'b0;
            listo_q     <= 1'b0;
            y_q         <= 1'b0;
            igual_q     <= 1'b0;
            menor_q     <= 1'b0;
        end else begin
            case (estado_q)
                ESPERA: begin
                    listo_q <= 1'b0;
                    if (inicio) begin
                        a_q         <= fn_es_signo(modo) ? (a ^ SIGNO) : a;
                        b_q         <= fn_es_signo(modo) ? (b ^ SIGNO) : b;
                        modo_q      <= modo;
                        idx_q       <= IDX_TOP;
                        dif_q       <= 1'b0;
                        menor_int_q <= 1'b0;
                        ocupado_q   <= 1'b1;
                        estado_q    <= COMPARAR;
                    end
                end
                COMPARAR: begin
                    dif_q       <= dif_d;
                    menor_int_q <= menor_int_d;
                    if (termina) begin
                        igual_q  <= !dif_d;
                        menor_q  <= menor_int_d;
                        y_q      <= fn_resultado(modo_q, !dif_d, menor_int_d);
                        listo_q  <= 1'b1;
                        estado_q <= FIN;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                FIN: begin
                    listo_q   <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= ESPERA;
                end
                default: begin
                    listo_q   <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= ESPERA;
                end
            endcase
        end
    end

    assign ocupado = ocupado_q;
    assign listo   = listo_q;
    assign Y       = y_q;
    assign igual   = igual_q;
    assign menor   = menor_q;

endmodule

`default_nettype wire
